// File: rtl/bit_serial_subtractor_pkg.sv
// rtl/bit_serial_subtractor_pkg.sv - shared types and helpers for the bit-serial subtractor
package bit_serial_subtractor_pkg;

  // 2'd3 is never entered; the next-state logic sends it back to idle
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_e;

  // Bit counter must hold WIDTH-1; one spare bit keeps the compare simple
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_fs.sv
// rtl/bit_serial_subtractor_fs.sv - combinational one-bit full-subtractor cell
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Borrow is generated when a<b, or propagated when a==b and a borrow came in
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial A-B with valid/ready handshakes
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Result bits arrive LSB first; the MSB never needs storing because it is
  // appended straight from the cell on the final edge
  logic [WIDTH-2:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] r_next;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;

  logic             fs_d;
  logic             fs_bout;

  fs u_fs (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .bin (bor_q),
    .diff(fs_d),
    .bout(fs_bout)
  );

  assign r_next = {fs_d, r_sr_q};

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      r_sr_q       <= '0;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      r_sr_q       <= r_sr_d;
      bor_q        <= bor_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  // Next-state: accept in idle, run WIDTH edges, hold in done until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per run edge, capture result on the last
  always_comb begin
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    r_sr_d       = r_sr_q;
    bor_d        = bor_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      S_RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d = r_next[WIDTH-1:1];
        bor_d  = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          diff_d       = r_next;
          borrow_out_d = fs_bout;
          ovf_d        = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decode the registered state only
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - directed self-checking bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  int vectors;
  int miscompares;

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns edges taken since the sample point
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
    int lat;
    out_ready = 1'b1;
    a = av;
    b = bv;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    chk({tag, "_diff"}, 64'(diff), 64'(exp_d));
    chk({tag, "_borrow"}, 64'(borrow_out), 64'(exp_b));
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
    step();
    chk({tag, "_idle_after"}, 64'({in_ready, out_valid}), 64'b10);
    chk({tag, "_diff_held"}, 64'(diff), 64'(exp_d));
  endtask

  initial begin
    int lat;
    logic bad;
    logic [7:0] d_snap;
    logic       b_snap;
    logic       o_snap;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;

    step();
    step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_results", 64'({diff, borrow_out, ovf}), 64'd0);
    rst_n = 1'b1;
    step();

    run_op("t5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op("t10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    run_op("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Backpressure: result must hold for 20 clocks with in_ready low
    out_ready = 1'b0;
    a = 8'h5A;
    b = 8'h23;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'(WIDTH));
    d_snap = diff;
    b_snap = borrow_out;
    o_snap = ovf;
    chk("bp_diff", 64'(d_snap), 64'h37);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (diff !== d_snap || borrow_out !== b_snap || ovf !== o_snap ||
          in_ready !== 1'b0 || out_valid !== 1'b1)
        bad = 1'b1;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_release", 64'({in_ready, out_valid}), 64'b10);

    // Operands changing during run with in_valid held must not disturb the result
    out_ready = 1'b0;
    a = 8'h10;
    b = 8'h20;
    in_valid = 1'b1;
    step();
    bad = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      a = 8'(8'hC3 + lat);
      b = 8'(8'h11 * lat);
      if (in_ready !== 1'b0) bad = 1'b1;
      step();
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'(WIDTH));
    chk("hold_diff", 64'(diff), 64'hF0);
    chk("hold_borrow", 64'(borrow_out), 64'd1);
    a = 8'h09;
    b = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    chk("hold_no_accept", 64'(bad), 64'd0);
    out_ready = 1'b1;
    step();
    chk("hold_second_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("hold_second_running", 64'({in_ready, out_valid}), 64'b00);
    wait_out(lat);
    chk("hold_second_latency", 64'(lat), 64'(WIDTH));
    chk("hold_second_diff", 64'(diff), 64'h05);
    step();

    // Reset mid-run aborts and clears everything
    a = 8'hFF;
    b = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    chk("rst_run_in_ready", 64'(in_ready), 64'd1);
    chk("rst_run_out_valid", 64'(out_valid), 64'd0);
    chk("rst_run_results", 64'({diff, borrow_out, ovf}), 64'd0);
    rst_n = 1'b1;
    step();
    run_op("t05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
